// File: rtl/nvdla_csb_engine.sv
// Runs one NVDLA CSB access per start command, streams read data back, optionally waits for the interrupt.
// Optional: define NVDLA_CSB_TIMEOUT_EN to bound response/interrupt waits to TIMEOUT_CYCLES.
module nvdla_csb_engine #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        start_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdat_i,
  input  logic        write_i,
  input  logic        wait_intr_i,
  output logic        csb_valid_o,
  input  logic        csb_ready_i,
  output logic [15:0] csb_addr_o,
  output logic [31:0] csb_wdat_o,
  output logic        csb_write_o,
  output logic        csb_nposted_o,
  input  logic        csb_rvalid_i,
  input  logic [31:0] csb_rdata_i,
  input  logic        csb_wr_complete_i,
  input  logic        intr_i,
  output logic        rdata_valid_o,
  input  logic        rdata_ready_i,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    FSM_IDLE,
    FSM_START,
    FSM_CONSUME,
    FSM_WAIT,
    FSM_WAIT_INTR,
    FSM_TERMINATE
  } state_t;

  state_t      r_state;
  logic [15:0] r_addr;
  logic [31:0] r_wdat;
  logic        r_write;
  logic        r_wait_intr;
  logic [31:0] r_rdata;
  logic        r_sticky;
  logic        r_timeout;
  logic        w_expired;
  logic        w_cons_done;

  assign w_cons_done = r_write ? csb_wr_complete_i : csb_rvalid_i;

`ifdef NVDLA_CSB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_tmo_cnt;

  // Counter is zero outside the wait states; leaving CONSUME re-arms it for WAIT_INTR.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_tmo_cnt <= '0;
    end else if ((r_state != FSM_CONSUME && r_state != FSM_WAIT_INTR) ||
                 (r_state == FSM_CONSUME && w_cons_done)) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_expired = (r_tmo_cnt == LAST);
`else
  // Waits are unbounded: expiry can never occur.
  assign w_expired = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state     <= FSM_IDLE;
      r_addr      <= '0;
      r_wdat      <= '0;
      r_write     <= 1'b0;
      r_wait_intr <= 1'b0;
      r_rdata     <= '0;
      r_sticky    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state != FSM_IDLE && intr_i) r_sticky <= 1'b1;
      case (r_state)
        FSM_IDLE: begin
          if (start_i) begin
            r_addr      <= addr_i;
            r_wdat      <= wdat_i;
            r_write     <= write_i;
            r_wait_intr <= wait_intr_i;
            r_state     <= FSM_START;
          end
        end
        FSM_START: begin
          if (csb_ready_i) r_state <= FSM_CONSUME;
        end
        FSM_CONSUME: begin
          if (w_cons_done) begin
            if (r_write) begin
              r_state <= r_wait_intr ? FSM_WAIT_INTR : FSM_TERMINATE;
            end else begin
              r_rdata <= csb_rdata_i;
              r_state <= FSM_WAIT;
            end
          end else if (w_expired) begin
            r_timeout <= 1'b1;
            r_state   <= FSM_TERMINATE;
          end
        end
        FSM_WAIT: begin
          if (rdata_ready_i) r_state <= r_wait_intr ? FSM_WAIT_INTR : FSM_TERMINATE;
        end
        FSM_WAIT_INTR: begin
          if (intr_i || r_sticky) begin
            r_state <= FSM_TERMINATE;
          end else if (w_expired) begin
            r_timeout <= 1'b1;
            r_state   <= FSM_TERMINATE;
          end
        end
        FSM_TERMINATE: begin
          // Clear wins over a same-cycle interrupt so the next command starts clean.
          r_sticky <= 1'b0;
          r_state  <= FSM_IDLE;
        end
        default: r_state <= FSM_IDLE;
      endcase
    end
  end

  assign csb_valid_o   = (r_state == FSM_START);
  assign csb_addr_o    = r_addr;
  assign csb_wdat_o    = r_wdat;
  assign csb_write_o   = r_write;
  assign csb_nposted_o = 1'b1;
  assign rdata_valid_o = (r_state == FSM_WAIT);
  assign rdata_o       = r_rdata;
  assign busy_o        = (r_state != FSM_IDLE);
  assign done_o        = (r_state == FSM_TERMINATE);
  assign timeout_o     = r_timeout;

endmodule

// File: doc/nvdla_csb_engine.md
# nvdla_csb_engine

- Executes one NVDLA configuration-space bus (CSB) transaction per start command from the HWPE controller, and waits for completion.
- Sits downstream of the HWPE register file/controller and upstream of the NVDLA core's csb2nvdla/nvdla2csb ports.
- Returns read data to the HWPE side as a stream.
- Optionally blocks until the NVDLA interrupt fires before reporting done.

## Interface
- TIMEOUT_CYCLES, 1024: max cycles spent waiting for a CSB response or an interrupt; only used with NVDLA_CSB_TIMEOUT_EN.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- start_i  in  1  command strobe; accepted only in FSM_IDLE.
- addr_i  in  16  CSB word address.
- wdat_i  in  32  write data.
- write_i  in  1  1 = write, 0 = read.
- wait_intr_i  in  1  wait for the interrupt after the access completes.
- csb_valid_o  out  1  CSB request valid.
- csb_ready_i  in  1  CSB request ready.
- csb_addr_o  out  16  request address.
- csb_wdat_o  out  32  request write data.
- csb_write_o  out  1  request is a write.
- csb_nposted_o  out  1  non-posted write; constant 1.
- csb_rvalid_i  in  1  read response valid.
- csb_rdata_i  in  32  read response data.
- csb_wr_complete_i  in  1  write completion.
- intr_i  in  1  NVDLA interrupt, level.
- rdata_valid_o  out  1  read-data stream valid.
- rdata_ready_i  in  1  read-data stream ready.
- rdata_o  out  32  read data.
- busy_o  out  1  high whenever state is not FSM_IDLE.
- done_o  out  1  one-cycle completion pulse.
- timeout_o  out  1  one-cycle pulse coincident with done_o when the transaction was aborted.

## Operation
States are FSM_IDLE, FSM_START, FSM_CONSUME, FSM_WAIT, FSM_WAIT_INTR and FSM_TERMINATE.
- **FSM_IDLE**
  - On start_i, capture addr_i/wdat_i/write_i/wait_intr_i into command registers and go to FSM_START.
  - start_i in any other state is ignored.
- **FSM_START**
  - csb_valid_o=1, with address, data and write driven from the command registers.
  - Stay until csb_ready_i=1 in the same cycle, then go to FSM_CONSUME.
- **FSM_CONSUME**
  - Write: wait for csb_wr_complete_i.
  - Read: wait for csb_rvalid_i; capture csb_rdata_i into rdata_o, then go to FSM_WAIT.
  - Write complete: go to FSM_WAIT_INTR if wait_intr is set, else FSM_TERMINATE.
  - Responses arriving in any other state are dropped.
- **FSM_WAIT**
  - rdata_valid_o=1 with rdata_o stable until rdata_ready_i=1.
  - Then go to FSM_WAIT_INTR or FSM_TERMINATE, as for writes.
- **FSM_WAIT_INTR**
  - Leave for FSM_TERMINATE when intr_i=1 or the sticky interrupt flag is set.
  - The sticky flag is set by intr_i=1 in any non-IDLE state, so an early interrupt is not lost.
- **FSM_TERMINATE**
  - done_o=1 for one cycle.
  - Sticky interrupt flag cleared; next state FSM_IDLE.
- **Reset/clear** (any state, including mid-transaction)
  - State returns to FSM_IDLE; command registers, rdata_o and sticky flag are zeroed.
  - An in-flight CSB response is not awaited.

## Timing
- Reset values:
  - All outputs 0, except csb_nposted_o=1.
  - csb_addr_o, csb_wdat_o, csb_write_o, rdata_o = 0.
- Latency:
  - start_i at cycle N gives csb_valid_o=1 at N+1.
  - Minimum write: ready at N+1, wr_complete at N+2, done_o at N+3.
  - Minimum read: rvalid at N+2, rdata_valid_o at N+3; with ready at N+3, done_o at N+4.
- Handshakes:
  - csb_valid_o is never deasserted before csb_ready_i, and the request fields stay stable while it is held.
  - rdata_valid_o obeys the same rule for rdata_ready_i.
- busy_o is registered from state: 1 from N+1 through the cycle of done_o, and 0 in the cycle after done_o.
- A new start_i is accepted in the cycle after done_o.

## Configuration
- NVDLA_CSB_TIMEOUT_EN defined:
  - A cycle counter resets on entering FSM_CONSUME or FSM_WAIT_INTR and increments each cycle in those states.
  - When the counter equals TIMEOUT_CYCLES-1 with no exit condition met, go to FSM_TERMINATE and pulse timeout_o with done_o.
  - Counter width is $clog2(TIMEOUT_CYCLES).
  - A response and the expiry in the same cycle count as success.
- Not defined:
  - Waits are unbounded, no counter logic exists, and timeout_o is tied to 0.

## Test plan
- Write: start, addr=0x5010, wdat=0xDEADBEEF, write=1, wait_intr=0; ready held low 3 cycles -> request stable for 4 cycles, csb_nposted_o=1, done_o 1 cycle after csb_wr_complete_i.
- Read: addr=0x0004, csb_rdata_i=0x12345678; rdata_ready_i low 5 cycles -> rdata_valid_o held with 0x12345678, done_o the cycle after ready.
- Write with wait_intr=1, intr_i pulsed during FSM_START -> sticky flag set, FSM_WAIT_INTR exits immediately, done_o asserts.
- Back-to-back: start_i while busy is ignored; start_i the cycle after done_o is accepted, and the second transaction uses the new command.
- rst_i asserted in FSM_CONSUME, then a late csb_rvalid_i -> all outputs at reset values, no rdata_valid_o, no done_o.
- With NVDLA_CSB_TIMEOUT_EN and TIMEOUT_CYCLES=16, a read with no rvalid -> done_o and timeout_o together, exactly 16 cycles after entering FSM_CONSUME; busy_o=0 the next cycle.
